// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: triggered snapshot buffer for 32x9-bit deserialized words.
// Records continuously into a circular RAM once armed. After a trigger it records
// post_len more words, then plays the frozen record out oldest-first over valid/ready.
// Optional build macro: ADC_CAPTURE_LEVEL_TRIG_EN adds the thresh port and a level
// trigger on in_0 > thresh.
//
// state   | meaning
// S_IDLE  | waiting for arm, no writes
// S_ARMED | writing every cycle, waiting for trigger
// S_POST  | writing post-trigger words, post_cnt counts down
// S_READ  | frozen; one setup cycle, then words streamed out
module adc_capture_buffer #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        in_0,  input  logic [8:0] in_1,  input  logic [8:0] in_2,  input  logic [8:0] in_3,
  input  logic [8:0]        in_4,  input  logic [8:0] in_5,  input  logic [8:0] in_6,  input  logic [8:0] in_7,
  input  logic [8:0]        in_8,  input  logic [8:0] in_9,  input  logic [8:0] in_10, input  logic [8:0] in_11,
  input  logic [8:0]        in_12, input  logic [8:0] in_13, input  logic [8:0] in_14, input  logic [8:0] in_15,
  input  logic [8:0]        in_16, input  logic [8:0] in_17, input  logic [8:0] in_18, input  logic [8:0] in_19,
  input  logic [8:0]        in_20, input  logic [8:0] in_21, input  logic [8:0] in_22, input  logic [8:0] in_23,
  input  logic [8:0]        in_24, input  logic [8:0] in_25, input  logic [8:0] in_26, input  logic [8:0] in_27,
  input  logic [8:0]        in_28, input  logic [8:0] in_29, input  logic [8:0] in_30, input  logic [8:0] in_31,
  input  logic              arm,
  input  logic              trig,
  input  logic [ADDR_W-1:0] post_len,
  output logic              busy,
  output logic              done,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic [8:0]        out_0,  output logic [8:0] out_1,  output logic [8:0] out_2,  output logic [8:0] out_3,
  output logic [8:0]        out_4,  output logic [8:0] out_5,  output logic [8:0] out_6,  output logic [8:0] out_7,
  output logic [8:0]        out_8,  output logic [8:0] out_9,  output logic [8:0] out_10, output logic [8:0] out_11,
  output logic [8:0]        out_12, output logic [8:0] out_13, output logic [8:0] out_14, output logic [8:0] out_15,
  output logic [8:0]        out_16, output logic [8:0] out_17, output logic [8:0] out_18, output logic [8:0] out_19,
  output logic [8:0]        out_20, output logic [8:0] out_21, output logic [8:0] out_22, output logic [8:0] out_23,
  output logic [8:0]        out_24, output logic [8:0] out_25, output logic [8:0] out_26, output logic [8:0] out_27,
  output logic [8:0]        out_28, output logic [8:0] out_29, output logic [8:0] out_30, output logic [8:0] out_31
`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
  ,
  input  logic [8:0]        thresh
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int W     = 288;
  localparam logic [ADDR_W:0]   FILL_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_READ} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, post_cnt_q, post_cnt_d;
  logic [ADDR_W:0]   fill_q, fill_d, rem_q, rem_d, fill_inc;
  logic              prime_q, prime_d, busy_q, busy_d, done_q, done_d;
  logic              rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic [W-1:0]      out_q, out_d, in_w, ram_rd;
  logic              we, trig_hit, hs, ld, enter_read;
  logic [W-1:0]      ram [DEPTH];

  assign in_w = {in_31, in_30, in_29, in_28, in_27, in_26, in_25, in_24,
                 in_23, in_22, in_21, in_20, in_19, in_18, in_17, in_16,
                 in_15, in_14, in_13, in_12, in_11, in_10, in_9,  in_8,
                 in_7,  in_6,  in_5,  in_4,  in_3,  in_2,  in_1,  in_0};

`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
  assign trig_hit = trig | (in_0 > thresh);
`else
  assign trig_hit = trig;
`endif

  assign fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + CNT_ONE;
  assign hs       = rd_valid_q & rd_ready;
  assign ram_rd   = ram[rd_ptr_q];

  // Next-state, pointer/counter and read-pipeline computation
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    post_cnt_d = post_cnt_q;
    fill_d     = fill_q;
    rem_d      = rem_q;
    prime_d    = prime_q;
    done_d     = done_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    out_d      = out_q;
    we         = 1'b0;
    ld         = 1'b0;
    enter_read = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d  = S_ARMED;
          wr_ptr_d = '0;
          fill_d   = '0;
          done_d   = 1'b0;
        end
      end
      S_ARMED: begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        fill_d   = fill_inc;
        if (trig_hit) begin
          post_cnt_d = post_len;
          if (post_len == '0) enter_read = 1'b1;
          else                state_d    = S_POST;
        end
      end
      S_POST: begin
        we         = 1'b1;
        wr_ptr_d   = wr_ptr_q + PTR_ONE;
        fill_d     = fill_inc;
        post_cnt_d = post_cnt_q - PTR_ONE;
        if (post_cnt_q == PTR_ONE) enter_read = 1'b1;
      end
      default: begin
        // The setup cycle computes the oldest word; a full record wraps to wr_ptr itself.
        if (prime_q) begin
          prime_d  = 1'b0;
          rd_ptr_d = wr_ptr_q - fill_q[ADDR_W-1:0];
        end else begin
          if (hs) rd_valid_d = 1'b0;
          if (hs && rd_last_q) begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            rd_last_d = 1'b0;
          end
          ld = (rem_q != '0) && (!rd_valid_q || rd_ready);
          if (ld) begin
            out_d      = ram_rd;
            rd_valid_d = 1'b1;
            rd_last_d  = (rem_q == CNT_ONE);
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            rem_d      = rem_q - CNT_ONE;
          end
        end
      end
    endcase
    if (enter_read) begin
      state_d = S_READ;
      prime_d = 1'b1;
      rem_d   = fill_inc;
    end
  end

  assign busy_d = (state_d != S_IDLE);

  // Sample RAM: written in ARMED/POST, contents undefined after reset
  always_ff @(posedge clk) begin
    if (we) ram[wr_ptr_q] <= in_w;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      post_cnt_q <= '0;
      fill_q     <= '0;
      rem_q      <= '0;
      prime_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      post_cnt_q <= post_cnt_d;
      fill_q     <= fill_d;
      rem_q      <= rem_d;
      prime_q    <= prime_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      out_q      <= out_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;

  assign out_0  = out_q[9*0  +: 9]; assign out_1  = out_q[9*1  +: 9];
  assign out_2  = out_q[9*2  +: 9]; assign out_3  = out_q[9*3  +: 9];
  assign out_4  = out_q[9*4  +: 9]; assign out_5  = out_q[9*5  +: 9];
  assign out_6  = out_q[9*6  +: 9]; assign out_7  = out_q[9*7  +: 9];
  assign out_8  = out_q[9*8  +: 9]; assign out_9  = out_q[9*9  +: 9];
  assign out_10 = out_q[9*10 +: 9]; assign out_11 = out_q[9*11 +: 9];
  assign out_12 = out_q[9*12 +: 9]; assign out_13 = out_q[9*13 +: 9];
  assign out_14 = out_q[9*14 +: 9]; assign out_15 = out_q[9*15 +: 9];
  assign out_16 = out_q[9*16 +: 9]; assign out_17 = out_q[9*17 +: 9];
  assign out_18 = out_q[9*18 +: 9]; assign out_19 = out_q[9*19 +: 9];
  assign out_20 = out_q[9*20 +: 9]; assign out_21 = out_q[9*21 +: 9];
  assign out_22 = out_q[9*22 +: 9]; assign out_23 = out_q[9*23 +: 9];
  assign out_24 = out_q[9*24 +: 9]; assign out_25 = out_q[9*25 +: 9];
  assign out_26 = out_q[9*26 +: 9]; assign out_27 = out_q[9*27 +: 9];
  assign out_28 = out_q[9*28 +: 9]; assign out_29 = out_q[9*29 +: 9];
  assign out_30 = out_q[9*30 +: 9]; assign out_31 = out_q[9*31 +: 9];

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Testbench for adc_capture_buffer: random sample words, reference record kept as a
// queue of every word written since arm; expected record = last min(count, 64) words.
module tb_adc_capture_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         arm = 1'b0;
  logic         trig = 1'b0;
  logic [5:0]   post_len = '0;
  logic         rd_ready = 1'b0;
  logic         busy, done, rd_valid, rd_last;
  logic [287:0] din = '0;
  wire  [287:0] dout;
`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
  logic [8:0]   thresh = 9'h1FF;
`endif

  logic [287:0] hist[$];
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  adc_capture_buffer #(.ADDR_W(6)) dut (
    .clk(clk), .rst(rst),
    .in_0(din[9*0 +: 9]),   .in_1(din[9*1 +: 9]),   .in_2(din[9*2 +: 9]),   .in_3(din[9*3 +: 9]),
    .in_4(din[9*4 +: 9]),   .in_5(din[9*5 +: 9]),   .in_6(din[9*6 +: 9]),   .in_7(din[9*7 +: 9]),
    .in_8(din[9*8 +: 9]),   .in_9(din[9*9 +: 9]),   .in_10(din[9*10 +: 9]), .in_11(din[9*11 +: 9]),
    .in_12(din[9*12 +: 9]), .in_13(din[9*13 +: 9]), .in_14(din[9*14 +: 9]), .in_15(din[9*15 +: 9]),
    .in_16(din[9*16 +: 9]), .in_17(din[9*17 +: 9]), .in_18(din[9*18 +: 9]), .in_19(din[9*19 +: 9]),
    .in_20(din[9*20 +: 9]), .in_21(din[9*21 +: 9]), .in_22(din[9*22 +: 9]), .in_23(din[9*23 +: 9]),
    .in_24(din[9*24 +: 9]), .in_25(din[9*25 +: 9]), .in_26(din[9*26 +: 9]), .in_27(din[9*27 +: 9]),
    .in_28(din[9*28 +: 9]), .in_29(din[9*29 +: 9]), .in_30(din[9*30 +: 9]), .in_31(din[9*31 +: 9]),
    .arm(arm), .trig(trig), .post_len(post_len),
    .busy(busy), .done(done), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .out_0(dout[9*0 +: 9]),   .out_1(dout[9*1 +: 9]),   .out_2(dout[9*2 +: 9]),   .out_3(dout[9*3 +: 9]),
    .out_4(dout[9*4 +: 9]),   .out_5(dout[9*5 +: 9]),   .out_6(dout[9*6 +: 9]),   .out_7(dout[9*7 +: 9]),
    .out_8(dout[9*8 +: 9]),   .out_9(dout[9*9 +: 9]),   .out_10(dout[9*10 +: 9]), .out_11(dout[9*11 +: 9]),
    .out_12(dout[9*12 +: 9]), .out_13(dout[9*13 +: 9]), .out_14(dout[9*14 +: 9]), .out_15(dout[9*15 +: 9]),
    .out_16(dout[9*16 +: 9]), .out_17(dout[9*17 +: 9]), .out_18(dout[9*18 +: 9]), .out_19(dout[9*19 +: 9]),
    .out_20(dout[9*20 +: 9]), .out_21(dout[9*21 +: 9]), .out_22(dout[9*22 +: 9]), .out_23(dout[9*23 +: 9]),
    .out_24(dout[9*24 +: 9]), .out_25(dout[9*25 +: 9]), .out_26(dout[9*26 +: 9]), .out_27(dout[9*27 +: 9]),
    .out_28(dout[9*28 +: 9]), .out_29(dout[9*29 +: 9]), .out_30(dout[9*30 +: 9]), .out_31(dout[9*31 +: 9])
`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
    , .thresh(thresh)
`endif
  );

  function automatic logic [287:0] rand_word();
    logic [287:0] w;
    for (int j = 0; j < 9; j++) w[j*32 +: 32] = $urandom;
    return w;
  endfunction

  // Arm from IDLE; trig is randomly asserted alongside and must have no effect.
  task automatic do_arm();
    din  = rand_word();
    arm  = 1'b1;
    trig = 1'($urandom_range(0, 1));
    @(negedge clk);
    arm  = 1'b0;
    trig = 1'b0;
    vecs++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errs++;
      $display("FAIL arm_accept: busy=%b done=%b, expected busy=1 done=0", busy, done);
    end
    hist.delete();
  endtask

  // n_pre untriggered words, then the trigger word, then plen post words.
  task automatic write_words(input int n_pre, input int plen);
    for (int i = 0; i <= n_pre; i++) begin
      din      = rand_word();
      trig     = (i == n_pre);
      post_len = (i == n_pre) ? 6'(plen) : 6'($urandom);
      hist.push_back(din);
      @(negedge clk);
    end
    for (int i = 0; i < plen; i++) begin
      din      = rand_word();
      trig     = 1'($urandom_range(0, 1));
      post_len = 6'($urandom);
      hist.push_back(din);
      @(negedge clk);
    end
    trig = 1'b0;
  endtask

  // Entered at the first negedge after the READ entry edge.
  task automatic readout(input int ready_pct, input bit noise);
    int n, idx, budget;
    bit stalled;
    logic [287:0] held, expw;
    logic held_last;
    n = (hist.size() > 64) ? 64 : hist.size();
    idx = 0; budget = 3000; stalled = 0; held = '0; held_last = 1'b0;
    rd_ready = 1'b0;
    vecs++;
    if (rd_valid !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL read_entry: rd_valid=%b busy=%b, expected 0 1", rd_valid, busy);
    end
    @(negedge clk);
    vecs++;
    if (rd_valid !== 1'b0) begin
      errs++;
      $display("FAIL first_valid_early: rd_valid=%b expected 0", rd_valid);
    end
    @(negedge clk);
    vecs++;
    if (rd_valid !== 1'b1) begin
      errs++;
      $display("FAIL first_valid_late: rd_valid=%b expected 1", rd_valid);
    end
    while (idx < n && budget > 0) begin
      if (stalled) begin
        vecs++;
        if (rd_valid !== 1'b1 || dout !== held || rd_last !== held_last) begin
          errs++;
          $display("FAIL stall_hold: valid=%b last=%b out=%h, expected valid=1 last=%b out=%h",
                   rd_valid, rd_last, dout, held_last, held);
        end
      end
      if (ready_pct >= 100) begin
        vecs++;
        if (rd_valid !== 1'b1) begin
          errs++;
          $display("FAIL read_bubble: rd_valid=%b at word %0d, expected 1", rd_valid, idx);
        end
      end
      rd_ready = ($urandom_range(0, 99) < ready_pct);
      if (noise) begin
        arm  = 1'($urandom_range(0, 1));
        trig = 1'($urandom_range(0, 1));
      end
      stalled = 0;
      if (rd_valid === 1'b1) begin
        if (rd_ready) begin
          expw = hist[hist.size() - n + idx];
          vecs++;
          if (dout !== expw || rd_last !== (idx == n - 1)) begin
            errs++;
            $display("FAIL read_word[%0d/%0d]: out=%h last=%b, expected out=%h last=%b",
                     idx, n, dout, rd_last, expw, (idx == n - 1));
          end
          idx++;
        end else begin
          stalled   = 1;
          held      = dout;
          held_last = rd_last;
        end
      end
      @(negedge clk);
      budget--;
    end
    arm = 1'b0; trig = 1'b0; rd_ready = 1'b0;
    if (idx < n) begin
      errs++;
      $display("FAIL readout_timeout: got %0d words, expected %0d", idx, n);
    end
    vecs++;
    if (done !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0) begin
      errs++;
      $display("FAIL record_end: done=%b busy=%b rd_valid=%b, expected 1 0 0", done, busy, rd_valid);
    end
  endtask

  task automatic run_capture(input int n_pre, input int plen, input int ready_pct, input bit noise);
`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
    thresh = 9'h1FF;
`endif
    do_arm();
    write_words(n_pre, plen);
    readout(ready_pct, noise);
  endtask

  task automatic test_reset();
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || rd_last !== 1'b0 || dout !== '0) begin
      errs++;
      $display("FAIL reset_state: busy=%b done=%b valid=%b last=%b out=%h, expected all zero",
               busy, done, rd_valid, rd_last, dout);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_short();        run_capture(5, 3, 100, 0);   endtask
  task automatic test_wrap();         run_capture(100, 10, 100, 0); endtask
  task automatic test_post_zero();    run_capture(0, 0, 100, 0);   endtask
  task automatic test_long_post();    run_capture(3, 63, 100, 0);  endtask
  task automatic test_backpressure(); run_capture(12, 7, 50, 0);   endtask
  task automatic test_ignored_ctrl(); run_capture(15, 4, 70, 1);   endtask

  task automatic test_rst_in_post();
    do_arm();
    for (int i = 0; i < 6; i++) begin
      din = rand_word(); trig = (i == 5); post_len = 6'd20;
      @(negedge clk);
    end
    trig = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vecs++;
    if (busy !== 1'b0 || rd_valid !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL rst_in_post: busy=%b rd_valid=%b done=%b, expected 0 0 0", busy, rd_valid, done);
    end
    rst = 1'b0;
    @(negedge clk);
    run_capture(8, 2, 80, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++)
      run_capture($urandom_range(0, 130), $urandom_range(0, 63), $urandom_range(40, 100), 1'($urandom_range(0, 1)));
  endtask

`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
  task automatic test_level_trig();
    thresh = 9'd200;
    do_arm();
    post_len = 6'd2;
    for (int i = 0; i < 6; i++) begin
      din = rand_word();
      din[8:0] = 9'(50 * i);
      hist.push_back(din);
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      din = rand_word();
      hist.push_back(din);
      @(negedge clk);
    end
    readout(100, 0);
    thresh = 9'h1FF;
  endtask
`endif

  initial begin
    #2_000_000;
    errs++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_short();
    test_wrap();
    test_post_zero();
    test_long_post();
    test_backpressure();
    test_ignored_ctrl();
    test_rst_in_post();
    test_random();
`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
    test_level_trig();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
